// File: rtl/game_pay_arb_pkg.sv
// Shared constants and FSM state type for the payment arbiter slice.
package game_pkg;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned W     = 10;
  localparam int unsigned CAP   = 999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;
endpackage

// File: rtl/game_pay_arb_rr_pick.sv
// Combinational round-robin picker: first set request at index >= ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    int unsigned j;
    logic [PW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end
endmodule

// File: rtl/game_pay_arb.sv
// Round-robin top-up arbiter feeding a shared remain-time counter.
// Optional credit capping is compiled in with `define GAME_PAY_CAP_EN.
module game_pay_arb
  import game_pkg::*;
#(
  parameter int unsigned N_REQ = game_pkg::N_REQ,
  parameter int unsigned W     = game_pkg::W,
  parameter int unsigned CAP   = game_pkg::CAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] amount,
  input  logic [W-1:0]       remain_in,
  output logic [N_REQ-1:0]   ack,
  output logic               set,
  output logic [W-1:0]       money,
  output logic               clip,
  output logic               busy
);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [N_REQ-1:0]  pick_grant;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [W-1:0]      amt_sel;
  logic [W-1:0]      money_sel;
  logic              cap_hit;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    amt_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) amt_sel = amount[i*W +: W];
    end
  end

`ifdef GAME_PAY_CAP_EN
  always_comb begin
    logic [W:0] sum;
    sum       = {1'b0, remain_in} + {1'b0, amt_sel};
    money_sel = amt_sel;
    cap_hit   = 1'b0;
    if (sum > (W+1)'(CAP)) begin
      cap_hit   = 1'b1;
      money_sel = ({1'b0, remain_in} >= (W+1)'(CAP)) ? '0 : W'(CAP) - remain_in;
    end
  end
`else
  always_comb begin
    money_sel = amt_sel;
    cap_hit   = 1'b0;
  end
`endif

  // Strobes are loaded on the selection edge so they are visible exactly during GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      ack   <= '0;
      set   <= 1'b0;
      money <= '0;
      clip  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            win   <= pick_idx;
            ack   <= pick_grant;
            set   <= 1'b1;
            money <= money_sel;
            clip  <= cap_hit;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          ack   <= '0;
          set   <= 1'b0;
          money <= '0;
          clip  <= 1'b0;
          ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          state <= COOL;
        end
        COOL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_pay_arb.sv
// Self-checking bench for game_pay_arb: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_game_pay_arb;
  localparam int N   = 4;
  localparam int W   = 10;
  localparam int CAP = 999;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] amount;
  logic [W-1:0]   remain_in;
  logic [N-1:0]   ack;
  logic           set;
  logic [W-1:0]   money;
  logic           clip;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pointer, cycles left in the current transaction, expected outputs.
  int             m_ptr  = 0;
  int             m_left = 0;
  logic [N-1:0]   e_ack;
  logic           e_set, e_clip, e_busy;
  logic [W-1:0]   e_money;
  int             acks[$];
  int             ack_cyc[$];

  always #5 clk = ~clk;

  game_pay_arb #(
    .N_REQ (N),
    .W     (W),
    .CAP   (CAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .amount    (amount),
    .remain_in (remain_in),
    .ack       (ack),
    .set       (set),
    .money     (money),
    .clip      (clip),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    int n = 0;
    int id = 99;
    for (int i = 0; i < N; i++) if (v[i]) begin n++; id = i; end
    return (n == 1) ? id : 99;
  endfunction

  task automatic set_amt(input int i, input int v);
    amount[i*W +: W] = W'(v);
  endtask

  task automatic model_step();
    int w, a, mon, cl;
    e_ack = '0; e_set = 1'b0; e_money = '0; e_clip = 1'b0;
    if (rst) begin
      m_ptr = 0; m_left = 0;
    end else if (m_left == 0 && req != '0) begin
      w   = pick(req, m_ptr);
      a   = int'(amount[w*W +: W]);
      mon = a;
      cl  = 0;
`ifdef GAME_PAY_CAP_EN
      if (int'(remain_in) + a > CAP) begin
        mon = (int'(remain_in) >= CAP) ? 0 : CAP - int'(remain_in);
        cl  = 1;
      end
`endif
      e_ack   = N'(1) << w;
      e_set   = 1'b1;
      e_money = W'(mon);
      e_clip  = (cl != 0);
      m_left  = 2;
      m_ptr   = (w + 1) % N;
    end else if (m_left > 0) begin
      m_left--;
    end
    e_busy = (m_left > 0);
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later, returns at negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("ack",   ack,   e_ack);
    check("set",   set,   e_set);
    check("money", money, e_money);
    check("clip",  clip,  e_clip);
    check("busy",  busy,  e_busy);
    if (e_ack != '0) begin
      acks.push_back(oh2i(ack));
      ack_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    acks.delete();
    ack_cyc.delete();
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check({tag, "_n"}, acks.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acks.size(); i++)
      check(tag, acks[i], exp_q[i]);
  endtask

  initial begin
    int exp_q[$];
    rst = 1'b1; req = '0; amount = '0; remain_in = '0;
    @(negedge clk);
    cycle();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    cycle();

    // Single request, amount 50.
    rst = 1'b0;
    set_amt(0, 50); req = 4'b0001;
    cycle();
    check("t1_money", money, 50);
    check("t1_ack", ack, 1);
    check("t1_busy_g", busy, 1);
    req = '0;
    cycle();
    check("t1_busy_c", busy, 1);
    cycle();
    check("t1_busy_end", busy, 0);
    cycle();

    // All four continuously from reset.
    do_reset();
    for (int i = 0; i < N; i++) set_amt(i, 10 * (i + 1));
    req = 4'b1111;
    repeat (13) cycle();
    exp_q = '{0, 1, 2, 3, 0};
    check_order("rr_order", exp_q);
    for (int i = 1; i < ack_cyc.size(); i++)
      check("rr_gap", ack_cyc[i] - ack_cyc[i-1], 3);
    req = '0;
    repeat (3) cycle();

    // Fairness: 2 arrives during 0's grant, wins next.
    do_reset();
    set_amt(0, 5); set_amt(2, 7);
    req = 4'b0001;
    cycle();
    req = 4'b0101;
    repeat (6) cycle();
    exp_q = '{0, 2, 0};
    check_order("fair", exp_q);
    req = '0;
    repeat (3) cycle();

    // Cap boundary cases.
    do_reset();
    set_amt(1, 20); remain_in = W'(990); req = 4'b0010;
    cycle();
`ifdef GAME_PAY_CAP_EN
    check("cap_money", money, 9);
    check("cap_clip", clip, 1);
`else
    check("nocap_money", money, 20);
    check("nocap_clip", clip, 0);
`endif
    req = '0;
    repeat (2) cycle();
    remain_in = W'(999); req = 4'b0010;
    cycle();
`ifdef GAME_PAY_CAP_EN
    check("cap_full_money", money, 0);
    check("cap_full_clip", clip, 1);
`else
    check("nocap_full_money", money, 20);
    check("nocap_full_clip", clip, 0);
`endif
    req = '0; remain_in = '0;
    repeat (2) cycle();

    // Zero amount is still granted.
    set_amt(3, 0); req = 4'b1000;
    cycle();
    check("zero_set", set, 1);
    check("zero_ack", ack, 8);
    req = '0;
    repeat (2) cycle();

    // Reset during GRANT drops the transaction and clears the pointer.
    do_reset();
    set_amt(0, 33); set_amt(1, 11); set_amt(2, 77);
    req = 4'b0010;
    cycle();
    req = '0;
    repeat (2) cycle();
    req = 4'b0101;
    cycle();
    check("rg_pre_ack", ack, 4);
    rst = 1'b1;
    cycle();
    check("rg_ack", ack, 0);
    check("rg_set", set, 0);
    rst = 1'b0;
    repeat (6) cycle();
    exp_q = '{1, 2, 0, 2};
    check_order("rg_order", exp_q);
    req = '0;
    repeat (3) cycle();

    // Randomized traffic following the requester protocol.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && e_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_amt(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 1023));
        end else if (!req[i] && $urandom_range(0, 9) < 3) begin
          req[i] = 1'b1;
          set_amt(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 1023));
        end
      end
      remain_in = ($urandom_range(0, 3) == 0) ? W'($urandom_range(985, 1023)) : W'($urandom_range(0, 1023));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
